// File: rtl/risc_16bit_datapath.sv
// 16-bit RISC execution datapath: register file, registered read ports, ALU, write-back mux.
// Optional macro RF_READ_BYPASS_EN: same-cycle write-to-read forwarding on each read port.
module risc_16bit_datapath #(
    parameter int W  = 16,
    parameter int AW = 4,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] RF_W_data,
    input  logic          RF_s1,
    input  logic          RF_s0,
    input  logic [AW-1:0] RF_W_addr,
    input  logic          RF_W_wr,
    input  logic [AW-1:0] RF_Rp_addr,
    input  logic          RF_Rp_rd,
    input  logic [AW-1:0] RF_Rq_addr,
    input  logic          RF_Rq_rd,
    input  logic [2:0]    alu_s,
    input  logic [W-1:0]  R_data,
    output logic          RF_Rp_zero,
    output logic [W-1:0]  Rp_q,
    output logic [W-1:0]  Rq_q,
    output logic [W-1:0]  alu_q,
    output logic [W-1:0]  D_W_data
);

    localparam int NREG = 2 ** AW;

    logic [W-1:0] r_rf [NREG];
    logic [W-1:0] r_rp_q;
    logic [W-1:0] r_rq_q;
    logic [W-1:0] r_alu_q;

    logic [W-1:0] w_imm_sx;
    logic [W-1:0] w_wb_data;
    logic [W-1:0] w_alu_res;
    logic [W-1:0] w_rp_next;
    logic [W-1:0] w_rq_next;

    assign w_imm_sx = {{(W-IW){RF_W_data[IW-1]}}, RF_W_data};

    // Write-back source select: ALU, memory load, immediate, or register move
    always_comb begin
        w_wb_data = r_alu_q;
        unique case ({RF_s1, RF_s0})
            2'b00: w_wb_data = r_alu_q;
            2'b01: w_wb_data = R_data;
            2'b10: w_wb_data = w_imm_sx;
            2'b11: w_wb_data = r_rp_q;
        endcase
    end

    // Read-port data; with forwarding a same-index write wins over the array
    always_comb begin
        w_rp_next = r_rf[RF_Rp_addr];
        w_rq_next = r_rf[RF_Rq_addr];
`ifdef RF_READ_BYPASS_EN
        if (RF_W_wr && (RF_W_addr == RF_Rp_addr)) begin
            w_rp_next = w_wb_data;
        end
        if (RF_W_wr && (RF_W_addr == RF_Rq_addr)) begin
            w_rq_next = w_wb_data;
        end
`endif
    end

    // ALU operation on the registered operands; carries and borrows are dropped
    always_comb begin
        w_alu_res = '0;
        unique case (alu_s)
            3'b000: w_alu_res = r_rp_q + r_rq_q;
            3'b001: w_alu_res = r_rp_q - r_rq_q;
            3'b010: w_alu_res = r_rp_q & r_rq_q;
            3'b011: w_alu_res = r_rp_q | r_rq_q;
            3'b100: w_alu_res = r_rp_q ^ r_rq_q;
            3'b101: w_alu_res = ~r_rp_q;
            3'b110: w_alu_res = r_rp_q << 1;
            3'b111: w_alu_res = r_rp_q >> 1;
        endcase
    end

    // Register file write; every entry clears on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (RF_W_wr) begin
            r_rf[RF_W_addr] <= w_wb_data;
        end
    end

    // Read port registers hold their value when not enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rp_q <= '0;
            r_rq_q <= '0;
        end else begin
            if (RF_Rp_rd) begin
                r_rp_q <= w_rp_next;
            end
            if (RF_Rq_rd) begin
                r_rq_q <= w_rq_next;
            end
        end
    end

    // ALU result register, updated every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_q <= '0;
        end else begin
            r_alu_q <= w_alu_res;
        end
    end

    assign Rp_q       = r_rp_q;
    assign Rq_q       = r_rq_q;
    assign alu_q      = r_alu_q;
    assign D_W_data   = r_rp_q;
    assign RF_Rp_zero = (r_rp_q == '0);

endmodule

// File: tb/tb_risc_16bit_datapath.sv
// Directed self-checking bench for risc_16bit_datapath.
// Expected values are hand-computed constants.
module tb_risc_16bit_datapath;

    logic        clk;
    logic        reset;
    logic [7:0]  RF_W_data;
    logic        RF_s1;
    logic        RF_s0;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Rp_addr;
    logic        RF_Rp_rd;
    logic [3:0]  RF_Rq_addr;
    logic        RF_Rq_rd;
    logic [2:0]  alu_s;
    logic [15:0] R_data;
    logic        RF_Rp_zero;
    logic [15:0] Rp_q;
    logic [15:0] Rq_q;
    logic [15:0] alu_q;
    logic [15:0] D_W_data;

    int n_cmp;
    int n_err;

    risc_16bit_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .RF_W_data  (RF_W_data),
        .RF_s1      (RF_s1),
        .RF_s0      (RF_s0),
        .RF_W_addr  (RF_W_addr),
        .RF_W_wr    (RF_W_wr),
        .RF_Rp_addr (RF_Rp_addr),
        .RF_Rp_rd   (RF_Rp_rd),
        .RF_Rq_addr (RF_Rq_addr),
        .RF_Rq_rd   (RF_Rq_rd),
        .alu_s      (alu_s),
        .R_data     (R_data),
        .RF_Rp_zero (RF_Rp_zero),
        .Rp_q       (Rp_q),
        .Rq_q       (Rq_q),
        .alu_q      (alu_q),
        .D_W_data   (D_W_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h want 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_rdata(input logic [3:0] a, input logic [15:0] d);
        RF_s1 = 1'b0; RF_s0 = 1'b1;
        R_data = d; RF_W_addr = a; RF_W_wr = 1'b1;
        tick();
        RF_W_wr = 1'b0;
    endtask

    task automatic wr_imm(input logic [3:0] a, input logic [7:0] d);
        RF_s1 = 1'b1; RF_s0 = 1'b0;
        RF_W_data = d; RF_W_addr = a; RF_W_wr = 1'b1;
        tick();
        RF_W_wr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] p, input logic [3:0] q);
        RF_Rp_addr = p; RF_Rq_addr = q;
        RF_Rp_rd = 1'b1; RF_Rq_rd = 1'b1;
        tick();
        RF_Rp_rd = 1'b0; RF_Rq_rd = 1'b0;
    endtask

    logic [15:0] alu_exp [8];
    logic [15:0] same_exp;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        RF_W_data = '0; RF_s1 = 0; RF_s0 = 0;
        RF_W_addr = '0; RF_W_wr = 0;
        RF_Rp_addr = '0; RF_Rp_rd = 0;
        RF_Rq_addr = '0; RF_Rq_rd = 0;
        alu_s = 3'b000; R_data = '0;
        alu_exp = '{16'h0FFF, 16'hF1E1, 16'h0000, 16'h0FFF,
                    16'h0FFF, 16'hFF0F, 16'h01E0, 16'h0078};

        tick(); tick();
        chk("rst_rp", Rp_q, 16'h0000);
        chk("rst_rq", Rq_q, 16'h0000);
        chk("rst_alu", alu_q, 16'h0000);
        chk("rst_zero", {15'b0, RF_Rp_zero}, 16'h0001);
        reset = 1'b1;
        tick();

        // load R3, read it on both ports, let ALU add
        wr_rdata(4'd3, 16'h1234);
        rd(4'd3, 4'd3);
        chk("r3_rp", Rp_q, 16'h1234);
        chk("r3_rq", Rq_q, 16'h1234);
        chk("r3_nz", {15'b0, RF_Rp_zero}, 16'h0000);
        tick();
        chk("r3_add", alu_q, 16'h2468);

        // asynchronous reset mid-cycle
        #2;
        reset = 1'b0;
        #1;
        chk("arst_rp", Rp_q, 16'h0000);
        chk("arst_rq", Rq_q, 16'h0000);
        chk("arst_alu", alu_q, 16'h0000);
        chk("arst_zero", {15'b0, RF_Rp_zero}, 16'h0001);
        #1;
        reset = 1'b1;
        tick();
        rd(4'd3, 4'd3);
        chk("arst_r3", Rp_q, 16'h0000);

        // immediate sign extension
        wr_imm(4'd2, 8'h80);
        rd(4'd2, 4'd0);
        chk("imm_80", Rp_q, 16'hFF80);
        wr_imm(4'd2, 8'h7F);
        rd(4'd2, 4'd0);
        chk("imm_7f", Rp_q, 16'h007F);

        // ALU sweep over all operations
        wr_rdata(4'd1, 16'h00F0);
        wr_rdata(4'd2, 16'h0F0F);
        rd(4'd1, 4'd2);
        for (int i = 0; i < 8; i++) begin
            alu_s = 3'(i);
            tick();
            chk($sformatf("alu_%0d", i), alu_q, alu_exp[i]);
        end

        // wrap-around add, write back ALU result, zero flag
        wr_rdata(4'd5, 16'h5555);
        wr_imm(4'd8, 8'hFF);
        wr_imm(4'd9, 8'h01);
        alu_s = 3'b000;
        rd(4'd8, 4'd9);
        chk("wrap_rp", Rp_q, 16'hFFFF);
        chk("wrap_nz", {15'b0, RF_Rp_zero}, 16'h0000);
        tick();
        chk("wrap_alu", alu_q, 16'h0000);
        RF_s1 = 1'b0; RF_s0 = 1'b0;
        RF_W_addr = 4'd5; RF_W_wr = 1'b1;
        tick();
        RF_W_wr = 1'b0;
        rd(4'd5, 4'd9);
        chk("wb_r5", Rp_q, 16'h0000);
        chk("wb_zero", {15'b0, RF_Rp_zero}, 16'h0001);

        // memory load, then a disabled write must not disturb it
        wr_rdata(4'd7, 16'hBEEF);
        RF_s1 = 1'b0; RF_s0 = 1'b1;
        R_data = 16'h1111; RF_W_addr = 4'd7; RF_W_wr = 1'b0;
        tick();
        rd(4'd7, 4'd7);
        chk("ld_r7", Rp_q, 16'hBEEF);
        chk("ld_store", D_W_data, 16'hBEEF);
        RF_Rp_addr = 4'd2;
        RF_Rq_addr = 4'd2;
        tick();
        chk("hold_rp", Rp_q, 16'hBEEF);
        chk("hold_rq", Rq_q, 16'hBEEF);

        // register move from Rp_q
        RF_s1 = 1'b1; RF_s0 = 1'b1;
        RF_W_addr = 4'd10; RF_W_wr = 1'b1;
        tick();
        RF_W_wr = 1'b0;
        rd(4'd0, 4'd10);
        chk("mov_r10", Rq_q, 16'hBEEF);

        // same-cycle read and write of R4
        wr_imm(4'd4, 8'h01);
`ifdef RF_READ_BYPASS_EN
        same_exp = 16'h0002;
`else
        same_exp = 16'h0001;
`endif
        RF_s1 = 1'b1; RF_s0 = 1'b0;
        RF_W_data = 8'h02; RF_W_addr = 4'd4; RF_W_wr = 1'b1;
        RF_Rp_addr = 4'd4; RF_Rp_rd = 1'b1;
        RF_Rq_addr = 4'd1; RF_Rq_rd = 1'b1;
        tick();
        RF_W_wr = 1'b0; RF_Rp_rd = 1'b0; RF_Rq_rd = 1'b0;
        chk("rw_same", Rp_q, same_exp);
        chk("rw_other", Rq_q, 16'h00F0);
        rd(4'd4, 4'd4);
        chk("rw_next", Rp_q, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
